// File: rtl/share_unit_pkg.sv
// share_unit_pkg
//   Layout helpers shared by the share encoder and the recombination logic, so
//   both ends of a masked link agree on where every share and every random bit
//   lives inside a packed word.
//   - sh_idx(i, k, d)  : bit position of share k of data bit i (i*d + k)
//   - rnd_idx(i, j, d) : bit position of random bit j of data bit i (i*(d-1) + j)
package share_unit_pkg;

  function automatic int sh_idx(input int i, input int k, input int d);
    return i * d + k;
  endfunction

  function automatic int rnd_idx(input int i, input int j, input int d);
    return i * (d - 1) + j;
  endfunction

endpackage

// File: rtl/share_unit_if.sv
// share_unit_if
//   Bundles the three streams of the share unit: unshared words in, fresh
//   randomness in, shared words out.
//   Handshake rule for all three streams: a transfer happens on a rising clock
//   edge where valid & ready are both 1. A producer keeps its data stable and
//   valid asserted until that edge. ready may depend combinationally on the
//   other stream's valid, but valid never depends on ready.
//   Modports:
//     slave  - the share unit itself (consumes in/rnd, produces sh_out)
//     master - whatever feeds it and drains it
import share_unit_pkg::*;

interface share_unit_if #(
  parameter int d     = 2,
  parameter int count = 8
);
  logic [count-1:0]       in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [(d-1)*count-1:0] rnd_data;
  logic                   rnd_valid;
  logic                   rnd_ready;
  logic [d*count-1:0]     sh_out;
  logic                   out_valid;
  logic                   out_ready;

  modport slave (
    input  in_data, in_valid, rnd_data, rnd_valid, out_ready,
    output in_ready, rnd_ready, sh_out, out_valid
  );

  modport master (
    output in_data, in_valid, rnd_data, rnd_valid, out_ready,
    input  in_ready, rnd_ready, sh_out, out_valid
  );
endinterface

// File: rtl/share_unit_encode.sv
// share_encode
//   Purely combinational d-share Boolean masking of one word.
//   Ports:
//     in_data  [count]         unshared word
//     rnd_data [(d-1)*count]   randomness; bit rnd_idx(i,j) becomes share j+1 of bit i
//     shares   [d*count]       share k of bit i at sh_idx(i,k)
//   Share 0 absorbs the data bit XOR-ed with all random shares, so the XOR of
//   the d shares of a bit gives back the data bit.
import share_unit_pkg::*;

module share_encode #(
  parameter int d     = 2,
  parameter int count = 8
) (
  input  logic [count-1:0]       in_data,
  input  logic [(d-1)*count-1:0] rnd_data,
  output logic [d*count-1:0]     shares
);

  for (genvar i = 0; i < count; i++) begin : g_bit
    logic [d-2:0] r;
    assign r = rnd_data[rnd_idx(i, 0, d) +: d-1];
    assign shares[sh_idx(i, 0, d)] = in_data[i] ^ (^r);
    for (genvar k = 1; k < d; k++) begin : g_share
      assign shares[sh_idx(i, k, d)] = r[k-1];
    end
  end

endmodule

// File: rtl/share_unit.sv
// share_unit
//   Transmit-side masking stage: takes an unshared word plus fresh randomness,
//   both on valid/ready streams, and emits a registered d-share encoding in the
//   same interleaved layout the recombiner consumes.
//   Ports:
//     clk      rising-edge clock
//     syn_rst  synchronous active-high reset
//     bus      share_unit_if.slave (in_*, rnd_*, sh_out/out_valid/out_ready)
//     n_words  count of output handshakes since reset, wraps mod 2^CNT_W
//   Data and randomness are only ever consumed together, so no random word is
//   spent on a data word that is not taken, and vice versa.
import share_unit_pkg::*;

module share_unit #(
  parameter int d     = 2,
  parameter int count = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             syn_rst,
  share_unit_if.slave      bus,
  output logic [CNT_W-1:0] n_words
);

  if (d < 2) begin : g_bad_d
    $error("share_unit: d must be at least 2");
  end

  logic                   slot_free;
  logic                   fire;
  logic                   out_hs;
  logic [d*count-1:0]     enc;
  logic [d*count-1:0]     sh_q;
  logic                   out_valid_q;

  // The output register can take a new word when empty or when its current
  // word leaves on this same edge.
  assign slot_free = ~out_valid_q | bus.out_ready;
  assign fire      = bus.in_valid & bus.rnd_valid & slot_free & ~syn_rst;
  assign out_hs    = out_valid_q & bus.out_ready;

  // Each stream is ready only if the other one is valid: the two are consumed
  // on the same edge or not at all.
  assign bus.in_ready  = bus.rnd_valid & slot_free & ~syn_rst;
  assign bus.rnd_ready = bus.in_valid  & slot_free & ~syn_rst;

  share_encode #(
    .d     (d),
    .count (count)
  ) u_encode (
    .in_data  (bus.in_data),
    .rnd_data (bus.rnd_data),
    .shares   (enc)
  );

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      out_valid_q <= 1'b0;
      sh_q        <= '0;
      n_words     <= '0;
    end else begin
      if (fire) begin
        sh_q        <= enc;
        out_valid_q <= 1'b1;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
      if (out_hs) begin
        n_words <= n_words + CNT_W'(1);
      end
    end
  end

  assign bus.sh_out    = sh_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_share_unit.sv
module tb_share_unit;
  import share_unit_pkg::*;

  logic clk = 1'b0;
  logic rst2, rst3;
  logic [3:0]  n2;
  logic [15:0] n3;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] exp2_q[$];
  logic [23:0] exp3_q[$];
  logic [7:0]  dat3_q[$];

  share_unit_if #(.d(2), .count(8)) bus2 ();
  share_unit_if #(.d(3), .count(8)) bus3 ();

  share_unit #(.d(2), .count(8), .CNT_W(4)) dut2 (
    .clk     (clk),
    .syn_rst (rst2),
    .bus     (bus2.slave),
    .n_words (n2)
  );

  share_unit #(.d(3), .count(8), .CNT_W(16)) dut3 (
    .clk     (clk),
    .syn_rst (rst3),
    .bus     (bus3.slave),
    .n_words (n3)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference masking built straight from the layout definition.
  function automatic logic [63:0] enc_model(input int d, input logic [7:0] data,
                                            input logic [63:0] rnd);
    logic [63:0] s;
    logic b;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      b = data[i];
      for (int j = 0; j < d - 1; j++) begin
        s[i*d + j + 1] = rnd[i*(d-1) + j];
        b = b ^ rnd[i*(d-1) + j];
      end
      s[i*d] = b;
    end
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  // Present a word; return #1 after the edge it is accepted on, valids left high.
  task automatic send2(input logic [7:0] dat, input logic [7:0] rnd, input logic [15:0] exp);
    int n;
    bus2.in_data   = dat;
    bus2.rnd_data  = rnd;
    bus2.in_valid  = 1'b1;
    bus2.rnd_valid = 1'b1;
    #1;
    n = 0;
    while (!bus2.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus2.in_ready) begin
      total++;
      bad++;
      $display("FAIL send2 timeout: in_ready=0 expected 1");
    end else begin
      exp2_q.push_back(exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send3(input logic [7:0] dat, input logic [15:0] rnd);
    int n;
    bus3.in_data   = dat;
    bus3.rnd_data  = rnd;
    bus3.in_valid  = 1'b1;
    bus3.rnd_valid = 1'b1;
    #1;
    n = 0;
    while (!bus3.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus3.in_ready) begin
      total++;
      bad++;
      $display("FAIL send3 timeout: in_ready=0 expected 1");
    end else begin
      exp3_q.push_back(enc_model(3, dat, {48'd0, rnd}));
      dat3_q.push_back(dat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle2();
    bus2.in_valid  = 1'b0;
    bus2.rnd_valid = 1'b0;
  endtask

  task automatic idle3();
    bus3.in_valid  = 1'b0;
    bus3.rnd_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst2 && bus2.out_valid && bus2.out_ready) begin
      if (exp2_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut2 unexpected word: got %0h expected none", bus2.sh_out);
      end else begin
        e = exp2_q.pop_front();
        chk("dut2 sh_out", 64'(bus2.sh_out), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    logic [23:0] e;
    logic [7:0]  dt, rec;
    if (!rst3 && bus3.out_valid && bus3.out_ready) begin
      if (exp3_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut3 unexpected word: got %0h expected none", bus3.sh_out);
      end else begin
        e  = exp3_q.pop_front();
        dt = dat3_q.pop_front();
        for (int i = 0; i < 8; i++)
          rec[i] = bus3.sh_out[i*3] ^ bus3.sh_out[i*3+1] ^ bus3.sh_out[i*3+2];
        chk("dut3 sh_out", 64'(bus3.sh_out), 64'(e));
        chk("dut3 recombine", 64'(rec), 64'(dt));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int n;
    rst2 = 1'b1;
    rst3 = 1'b1;
    bus2.in_data = 8'h00; bus2.rnd_data = 8'h00;
    bus3.in_data = 8'h00; bus3.rnd_data = 16'h0000;
    bus2.in_valid = 1'b1; bus2.rnd_valid = 1'b1; bus2.out_ready = 1'b1;
    bus3.in_valid = 1'b1; bus3.rnd_valid = 1'b1; bus3.out_ready = 1'b1;

    // Reset: readies forced low even with both valids high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", 64'(bus2.in_ready), 64'd0);
    chk("rst rnd_ready", 64'(bus2.rnd_ready), 64'd0);
    chk("rst out_valid", 64'(bus2.out_valid), 64'd0);
    chk("rst sh_out", 64'(bus2.sh_out), 64'd0);
    chk("rst n_words", 64'(n2), 64'd0);
    chk("rst3 out_valid", 64'(bus3.out_valid), 64'd0);
    @(posedge clk);
    #1;
    idle2();
    idle3();
    rst2 = 1'b0;
    rst3 = 1'b0;
    @(posedge clk);
    #1;

    // Basic encoding d=2.
    send2(8'hA5, 8'h3C, 16'h4BE1);
    idle2();
    repeat (2) @(negedge clk);
    chk("enc n_words", 64'(n2), 64'd1);
    chk("enc drained", 64'(bus2.out_valid), 64'd0);

    // Stall on randomness.
    @(posedge clk);
    #1;
    bus2.in_data  = 8'h0F;
    bus2.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall in_ready", 64'(bus2.in_ready), 64'd0);
      chk("stall rnd_ready", 64'(bus2.rnd_ready), 64'd1);
      chk("stall out_valid", 64'(bus2.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send2(8'h0F, 8'h33, 16'h0F5A);
    idle2();
    repeat (3) @(negedge clk);
    chk("stall n_words", 64'(n2), 64'd2);

    // Backpressure.
    @(posedge clk);
    #1;
    bus2.out_ready = 1'b0;
    send2(8'hFF, 8'h00, 16'h5555);
    bus2.in_data  = 8'h00;
    bus2.rnd_data = 8'hFF;
    repeat (5) begin
      @(negedge clk);
      chk("bp sh_out", 64'(bus2.sh_out), 64'h5555);
      chk("bp out_valid", 64'(bus2.out_valid), 64'd1);
      chk("bp in_ready", 64'(bus2.in_ready), 64'd0);
      chk("bp rnd_ready", 64'(bus2.rnd_ready), 64'd0);
      chk("bp n_words", 64'(n2), 64'd2);
    end
    @(posedge clk);
    #1;
    bus2.out_ready = 1'b1;
    c0 = cyc;
    send2(8'h00, 8'hFF, 16'hFFFF);
    send2(8'hFF, 8'hFF, 16'hAAAA);
    send2(8'h00, 8'h00, 16'h0000);
    chk("bp throughput cycles", 64'(cyc - c0), 64'd3);
    idle2();
    repeat (3) @(negedge clk);
    chk("bp n_words after", 64'(n2), 64'd6);

    // Counter wrap: 11 more words brings the total to 17.
    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++)
      send2(8'(i * 29 + 3), 8'(i * 7), 16'(enc_model(2, 8'(i * 29 + 3), 64'(8'(i * 7)))));
    idle2();
    repeat (3) @(negedge clk);
    chk("wrap n_words", 64'(n2), 64'd1);

    // Reset mid-operation: a held word, a pending fire and an output handshake.
    @(posedge clk);
    #1;
    bus2.out_ready = 1'b0;
    send2(8'h3C, 8'h5A, 16'(enc_model(2, 8'h3C, 64'h5A)));
    bus2.in_data   = 8'h11;
    bus2.rnd_data  = 8'h22;
    bus2.out_ready = 1'b1;
    rst2 = 1'b1;
    @(negedge clk);
    chk("midrst in_ready", 64'(bus2.in_ready), 64'd0);
    chk("midrst rnd_ready", 64'(bus2.rnd_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("midrst out_valid", 64'(bus2.out_valid), 64'd0);
    chk("midrst n_words", 64'(n2), 64'd0);
    chk("midrst sh_out", 64'(bus2.sh_out), 64'd0);
    exp2_q.delete();
    rst2 = 1'b0;
    idle2();
    @(posedge clk);
    #1;
    send2(8'hA5, 8'h3C, 16'h4BE1);
    idle2();
    repeat (3) @(negedge clk);
    chk("post rst n_words", 64'(n2), 64'd1);

    // Streaming, d=3, back to back.
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int i = 0; i < 256; i++)
      send3(8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
    chk("stream cycles", 64'(cyc - c0), 64'd256);
    idle3();
    repeat (3) @(negedge clk);
    chk("stream n_words", 64'(n3), 64'd256);

    // Drain check.
    n = 0;
    while ((exp2_q.size() != 0 || exp3_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("dut2 queue empty", 64'(exp2_q.size()), 64'd0);
    chk("dut3 queue empty", 64'(exp3_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/share_unit.md
Name: share_unit

Overview:
- Transmit-side counterpart of the share recombination logic.
- Accepts unshared data words on a valid/ready stream and consumes fresh randomness on a second valid/ready stream.
- Emits a d-share Boolean masking of each word, registered, in the same bit-interleaved share layout the recombination logic consumes.
- Used in testbenches to feed shared plaintext/key material into the masked core and to check round-trip against the recombiner.

Parameters:
d, 2, number of shares; d >= 2 is required, elaboration fails otherwise.
count, 8, number of unshared bits per word.
CNT_W, 16, width of the transferred-word counter.

Ports:
clk  input  1  clock; all logic is rising-edge.
syn_rst  input  1  reset, synchronous, active-high.
in_data  input  count  unshared word.
in_valid  input  1  in_data valid.
in_ready  output  1  word accepted when in_valid & in_ready.
rnd_data  input  (d-1)*count  fresh randomness; bit i*(d-1)+j is share j+1 of data bit i.
rnd_valid  input  1  rnd_data valid.
rnd_ready  output  1  randomness consumed when rnd_valid & rnd_ready.
sh_out  output  d*count  shared word; bits [i*d +: d] are the d shares of bit i, and share k sits at bit i*d+k.
out_valid  output  1  sh_out valid.
out_ready  input  1  consumer accepts when out_valid & out_ready.
n_words  output  CNT_W  number of words emitted since reset.

Behaviour:
- Reset (syn_rst=1 at a clock edge): out_valid=0, sh_out=0, n_words=0.
  - Any held word is discarded.
  - in_ready=0 and rnd_ready=0 are forced combinationally while syn_rst=1.
- Slot free condition: slot_free = ~out_valid | out_ready.
- Accept (fire) conditions:
  - fire = in_valid & rnd_valid & slot_free & ~syn_rst.
  - in_ready = rnd_valid & slot_free & ~syn_rst.
  - rnd_ready = in_valid & slot_free & ~syn_rst.
  - Data and randomness are always consumed in the same cycle; neither stream is consumed alone.
- Encoding on fire, for every bit i:
  - Shares 1..d-1 = rnd_data[i*(d-1) +: d-1].
  - Share 0 = in_data[i] XOR (XOR of those d-1 random bits).
  - The XOR of all d shares of bit i equals in_data[i].
- Latency: exactly 1 cycle. On the edge where fire=1, sh_out is loaded and out_valid=1 from the next cycle.
- Output register:
  - Holds sh_out stable while out_valid & ~out_ready.
  - Clears out_valid on an output handshake without a simultaneous fire.
  - Simultaneous output handshake and fire: the new word replaces the old one, out_valid stays 1, full throughput of 1 word/cycle.
- Backpressure: while out_valid & ~out_ready, both ready outputs are 0 and no randomness is consumed or wasted.
- n_words:
  - Increments by 1 on each output handshake (out_valid & out_ready).
  - Wraps modulo 2^CNT_W, so all-ones + 1 = 0.
- Reset mid-transfer:
  - The reset edge dominates a concurrent fire and a concurrent output handshake: nothing is loaded and the counter does not increment.
- sh_out contents while out_valid=0 are don't-care for consumers. The implementation keeps the last value; the value after reset is 0.

Decomposition:
- Shared package/header holds:
  - the share-index helper constant SH_IDX(i,k) = i*d+k;
  - the randomness-index helper RND_IDX(i,j) = i*(d-1)+j.
  - The recombination logic uses the same SH_IDX so both ends share one layout definition.
- One sub-module, share_encode: purely combinational per-word encoder (in_data, rnd_data -> shares), using a generate loop over bits.
- The top module holds the handshake, output register and counter.

Test Plan:
- Encoding, d=2, count=8: in_data=0xA5, rnd_data=0x3C, all valid, out_ready=1 -> one cycle later out_valid=1, sh_out=0x4BE1, n_words=1.
- Stall on randomness: in_valid=1, rnd_valid=0 for 3 cycles -> in_ready=0, out_valid stays 0. Raise rnd_valid -> exactly one word is emitted.
- Backpressure: out_ready=0 with out_valid=1 for 5 cycles -> sh_out stable, in_ready=rnd_ready=0, n_words unchanged. Release -> resume at 1 word/cycle.
- Streaming: 256 back-to-back words with random data/rnd, d=3, out_ready=1 -> recombination of each sh_out equals its in_data, and n_words=256.
- Counter wrap, CNT_W=4: 17 transfers -> n_words=1.
- Reset mid-operation: syn_rst=1 while out_valid=1 and fire pending -> next cycle out_valid=0, n_words=0, no handshake counted.
